window_serializer: RTL and testbench

- Converts a full Tn×K×K feature window back into a stream of K columns, each Tn×K words wide. It is the transmit-side inverse of the vertical column-to-window register.
- Used on the writeback path: PE/select-array output windows are flattened into columns for the feature buffer. It also serves as a column source for loopback testing of the vertical register.
- Column order and bit packing mirror the vertical register exactly. Feeding its output back into the vertical register reproduces the original window.

---
 rtl/window_serializer_pkg.sv | 32 +++
 rtl/window_serializer_group_col_shifter.sv | 59 +++++
 rtl/window_serializer.sv | 115 +++++++++++
 tb/tb_window_serializer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_serializer_pkg.sv
// Shared definitions for the window serializer: default geometry, kernel
// mode encodings, derived bus widths and the serializer FSM state type.
package window_serializer_pkg;

   localparam int TN_DEF = 4;
   localparam int K_DEF  = 5;
   localparam int K3_DEF = 3;
   localparam int FW_DEF = 16;

   // kn_size_mode encodings
   localparam logic MODE_5X5 = 1'b0;
   localparam logic MODE_3X3 = 1'b1;

   localparam int WIN_BITS      = TN_DEF * K_DEF * K_DEF * FW_DEF;
   localparam int COL_BITS      = TN_DEF * K_DEF * FW_DEF;
   localparam int KERNEL_3_BITS = 9 * FW_DEF;
   localparam int CNT_W         = $clog2(K_DEF);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } ser_state_t;

   // Number of columns emitted for one window in the given mode.
   function automatic int unsigned cols_per_window(input logic        mode,
                                                   input logic        mode5_enc,
                                                   input int unsigned k5,
                                                   input int unsigned k3);
      return (mode == mode5_enc) ? k5 : k3;
   endfunction

endpackage

// File: rtl/window_serializer_group_col_shifter.sv
// One channel group of the serializer: holds a K*K pixel window and shifts
// it out one column per handshake, always presenting the top slice.
// In 3x3 mode the two 3x3 sub-windows shift independently inside their own
// fields so that each keeps its current column at its top.
module window_serializer_group_col_shifter
   import window_serializer_pkg::*;
#(
   parameter int KERNEL_SIZE   = K_DEF,
   parameter int KERNEL_SIZE_3 = K3_DEF,
   parameter int FEATURE_WIDTH = FW_DEF
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic                                          load,
   input  logic                                          shift,
   input  logic                                          mode_3x3,
   input  logic [KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] load_data,
   output logic [KERNEL_SIZE*FEATURE_WIDTH-1:0]          col_data
);

   localparam int GRP_W   = KERNEL_SIZE * KERNEL_SIZE * FEATURE_WIDTH;
   localparam int SLICE_W = KERNEL_SIZE * FEATURE_WIDTH;
   localparam int SUB_W   = KERNEL_SIZE_3 * KERNEL_SIZE_3 * FEATURE_WIDTH;
   localparam int SUBSL_W = KERNEL_SIZE_3 * FEATURE_WIDTH;

   logic [GRP_W-1:0] grp_q;
   logic [GRP_W-1:0] shifted_3x3;

   // Sub-window a (low field) and b (next field) each advance by one 3-word column.
   always_comb begin
      shifted_3x3                    = grp_q;
      shifted_3x3[SUB_W-1:0]         = grp_q[SUB_W-1:0] << SUBSL_W;
      shifted_3x3[2*SUB_W-1:SUB_W]   = grp_q[2*SUB_W-1:SUB_W] << SUBSL_W;
   end

   // Window register: load a new window or advance by one column.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grp_q <= '0;
      end else if (load) begin
         grp_q <= load_data;
      end else if (shift) begin
         if (mode_3x3) grp_q <= shifted_3x3;
         else          grp_q <= grp_q << SLICE_W;
      end
   end

   // Column extract: top slice in 5x5; a column plus b's top word in 3x3.
   always_comb begin
      col_data = '0;
      if (mode_3x3) begin
         col_data[SUBSL_W-1:0]                 = grp_q[SUB_W-1 -: SUBSL_W];
         col_data[SUBSL_W+FEATURE_WIDTH-1 -: FEATURE_WIDTH] = grp_q[2*SUB_W-1 -: FEATURE_WIDTH];
      end else begin
         col_data = grp_q[GRP_W-1 -: SLICE_W];
      end
   end

endmodule

// File: rtl/window_serializer.sv
// Window serializer top: accepts a Tn x K x K window and streams it out as
// K (5x5) or 3 (dual 3x3) columns with valid/ready flow control. Holds the
// control FSM, column counter, ping-pong bank select and completion pulse.
module window_serializer
   import window_serializer_pkg::*;
#(
   parameter int   Tn                 = TN_DEF,
   parameter int   KERNEL_SIZE        = K_DEF,
   parameter int   KERNEL_SIZE_3      = K3_DEF,
   parameter int   FEATURE_WIDTH      = FW_DEF,
   parameter logic KERNEL_SIZE_5_MODE = MODE_5X5,
   parameter logic KERNEL_SIZE_3_MODE = MODE_3X3
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               kn_size_mode,
   input  logic                                               win_valid,
   output logic                                               win_ready,
   input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] win_data,
   output logic                                               col_valid,
   input  logic                                               col_ready,
   output logic [Tn*KERNEL_SIZE*FEATURE_WIDTH-1:0]            col_data,
   output logic                                               col_last,
   output logic                                               col_sel,
   output logic                                               win_done
);

   localparam int GRP_W = KERNEL_SIZE * KERNEL_SIZE * FEATURE_WIDTH;
   localparam int COLG_W = KERNEL_SIZE * FEATURE_WIDTH;
   localparam int CW = $clog2(KERNEL_SIZE);

   ser_state_t      state_q, state_nx;
   logic [CW-1:0]   cnt_q;
   logic [CW-1:0]   last_idx;
   logic            mode_q;
   logic            col_sel_q;
   logic            win_done_p1;
   logic            at_last;
   logic            accept;
   logic            hs;
   logic            last_hs;

   assign last_idx = CW'(cols_per_window(mode_q, KERNEL_SIZE_5_MODE,
                                         KERNEL_SIZE, KERNEL_SIZE_3) - 1);
   assign at_last  = (cnt_q == last_idx);
   assign accept   = win_valid & win_ready;
   assign hs       = col_valid & col_ready;
   assign last_hs  = hs & col_last;
   assign col_sel  = col_sel_q;
   assign win_done = win_done_p1;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_nx;
   end

   // Next state and handshake outputs; a window can be taken in the last-column cycle.
   always_comb begin
      state_nx  = state_q;
      win_ready = 1'b0;
      col_valid = 1'b0;
      col_last  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            win_ready = 1'b1;
            if (win_valid) state_nx = ST_SHIFT;
         end
         ST_SHIFT: begin
            col_valid = 1'b1;
            col_last  = at_last;
            win_ready = at_last & col_ready;
            if (at_last && col_ready && !win_valid) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Column counter, latched mode, bank select and the completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         mode_q      <= KERNEL_SIZE_5_MODE;
         col_sel_q   <= 1'b0;
         win_done_p1 <= 1'b0;
      end else begin
         win_done_p1 <= last_hs;
         if (accept) begin
            cnt_q     <= '0;
            mode_q    <= kn_size_mode;
            col_sel_q <= ~col_sel_q;
         end else if (hs) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   // Per-group column shifters; a load in the last-column cycle wins over the shift.
   for (genvar g = 0; g < Tn; g++) begin : g_grp
      window_serializer_group_col_shifter #(
         .KERNEL_SIZE   (KERNEL_SIZE),
         .KERNEL_SIZE_3 (KERNEL_SIZE_3),
         .FEATURE_WIDTH (FEATURE_WIDTH)
      ) u_shifter (
         .clk       (clk),
         .rst_n     (rst_n),
         .load      (accept),
         .shift     (hs & ~accept),
         .mode_3x3  (mode_q == KERNEL_SIZE_3_MODE),
         .load_data (win_data[g*GRP_W +: GRP_W]),
         .col_data  (col_data[g*COLG_W +: COLG_W])
      );
   end

endmodule

// File: tb/tb_window_serializer.sv
// Directed testbench for window_serializer: single 5x5 window, back-to-back
// windows, dual 3x3 packing, backpressure, asynchronous reset mid-window and
// loopback reassembly through a vertical-register model.
module tb_window_serializer;

   localparam int TN = 4;
   localparam int K  = 5;
   localparam int FW = 16;
   localparam int GB = K * K * FW;
   localparam int SB = K * FW;
   localparam int WB = TN * GB;
   localparam int CB = TN * SB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          kn_size_mode;
   logic          win_valid;
   logic          win_ready;
   logic [WB-1:0] win_data;
   logic          col_valid;
   logic          col_ready;
   logic [CB-1:0] col_data;
   logic          col_last;
   logic          col_sel;
   logic          win_done;

   int n_cmp = 0;
   int n_bad = 0;

   window_serializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .kn_size_mode (kn_size_mode),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .win_data     (win_data),
      .col_valid    (col_valid),
      .col_ready    (col_ready),
      .col_data     (col_data),
      .col_last     (col_last),
      .col_sel      (col_sel),
      .win_done     (win_done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // 5x5 window: column c of group g word j = {tag, g, c, j}, column 0 in the top slice.
   function automatic logic [WB-1:0] make_win5(input logic [3:0] tag);
      logic [WB-1:0] w;
      w = '0;
      for (int g = 0; g < TN; g++)
         for (int c = 0; c < K; c++)
            for (int j = 0; j < K; j++)
               w[g*GB + (K-1-c)*SB + j*FW +: FW] = {tag, 4'(g), 4'(c), 4'(j)};
      return w;
   endfunction

   function automatic logic [CB-1:0] exp_col5(input logic [3:0] tag, input int c);
      logic [CB-1:0] col;
      col = '0;
      for (int g = 0; g < TN; g++)
         for (int j = 0; j < K; j++)
            col[g*SB + j*FW +: FW] = {tag, 4'(g), 4'(c), 4'(j)};
      return col;
   endfunction

   // 3x3 window: a word w = 0x1gw, b word w = 0x2gw, words above 18 filled with junk.
   function automatic logic [WB-1:0] make_win3();
      logic [WB-1:0] w;
      w = '0;
      for (int g = 0; g < TN; g++) begin
         for (int i = 0; i < 9; i++) begin
            w[g*GB + i*FW +: FW]     = 16'h0100 | 16'(g << 4) | 16'(i);
            w[g*GB + (9+i)*FW +: FW] = 16'h0200 | 16'(g << 4) | 16'(i);
         end
         for (int i = 18; i < 25; i++) w[g*GB + i*FW +: FW] = 16'hDEAD;
      end
      return w;
   endfunction

   function automatic logic [CB-1:0] exp_col3(input int c);
      logic [CB-1:0] col;
      col = '0;
      for (int g = 0; g < TN; g++) begin
         for (int j = 0; j < 3; j++)
            col[g*SB + j*FW +: FW] = 16'h0100 | 16'(g << 4) | 16'(3*(2-c) + j);
         col[g*SB + 3*FW +: FW] = 16'h0200 | 16'(g << 4) | 16'(3*(2-c) + 2);
      end
      return col;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; win_valid = 1'b0; col_ready = 1'b0; kn_size_mode = 1'b0; win_data = '0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; win_valid = 1'b0; col_ready = 1'b0; kn_size_mode = 1'b0; win_data = '0;
      #3;
      n_cmp++; if (win_ready !== 1'b1) begin n_bad++; $display("FAIL reset win_ready got %b want 1", win_ready); end
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL reset col_valid got %b want 0", col_valid); end
      n_cmp++; if (col_last !== 1'b0) begin n_bad++; $display("FAIL reset col_last got %b want 0", col_last); end
      n_cmp++; if (col_sel !== 1'b0) begin n_bad++; $display("FAIL reset col_sel got %b want 0", col_sel); end
      n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL reset win_done got %b want 0", win_done); end
      n_cmp++; if (col_data !== '0) begin n_bad++; $display("FAIL reset col_data got %h want 0", col_data); end
      tick();
      rst_n = 1'b1;
      tick();
      n_cmp++; if (win_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release win_ready got %b want 1", win_ready); end
   endtask

   task automatic test_single5();
      do_reset();
      kn_size_mode = 1'b0; col_ready = 1'b1; win_data = make_win5(4'h5); win_valid = 1'b1;
      #1;
      n_cmp++; if (win_ready !== 1'b1) begin n_bad++; $display("FAIL single5 idle win_ready got %b want 1", win_ready); end
      tick();
      win_valid = 1'b0; win_data = '1;
      for (int c = 0; c < K; c++) begin
         #1;
         n_cmp++; if (col_valid !== 1'b1) begin n_bad++; $display("FAIL single5 col_valid c=%0d got %b want 1", c, col_valid); end
         n_cmp++; if (col_data !== exp_col5(4'h5, c)) begin n_bad++; $display("FAIL single5 col_data c=%0d got %h want %h", c, col_data, exp_col5(4'h5, c)); end
         n_cmp++; if (col_last !== (c == K-1)) begin n_bad++; $display("FAIL single5 col_last c=%0d got %b want %b", c, col_last, (c == K-1)); end
         n_cmp++; if (win_ready !== (c == K-1)) begin n_bad++; $display("FAIL single5 win_ready c=%0d got %b want %b", c, win_ready, (c == K-1)); end
         n_cmp++; if (col_sel !== 1'b1) begin n_bad++; $display("FAIL single5 col_sel c=%0d got %b want 1", c, col_sel); end
         n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL single5 win_done c=%0d got %b want 0", c, win_done); end
         tick();
      end
      #1;
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL single5 end col_valid got %b want 0", col_valid); end
      n_cmp++; if (win_done !== 1'b1) begin n_bad++; $display("FAIL single5 win_done pulse got %b want 1", win_done); end
      tick();
      n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL single5 win_done width got %b want 0", win_done); end
   endtask

   task automatic test_back_to_back();
      int pulses;
      logic [3:0] tag;
      do_reset();
      pulses = 0;
      kn_size_mode = 1'b0; col_ready = 1'b1; win_data = make_win5(4'h1); win_valid = 1'b1;
      tick();
      win_data = make_win5(4'h2);
      for (int k = 0; k < 2*K; k++) begin
         if (k == K) win_valid = 1'b0;
         #1;
         tag = (k < K) ? 4'h1 : 4'h2;
         n_cmp++; if (col_valid !== 1'b1) begin n_bad++; $display("FAIL b2b col_valid k=%0d got %b want 1", k, col_valid); end
         n_cmp++; if (col_data !== exp_col5(tag, k % K)) begin n_bad++; $display("FAIL b2b col_data k=%0d got %h want %h", k, col_data, exp_col5(tag, k % K)); end
         n_cmp++; if (col_last !== ((k % K) == K-1)) begin n_bad++; $display("FAIL b2b col_last k=%0d got %b", k, col_last); end
         n_cmp++; if (win_ready !== ((k % K) == K-1)) begin n_bad++; $display("FAIL b2b win_ready k=%0d got %b", k, win_ready); end
         n_cmp++; if (col_sel !== (k < K)) begin n_bad++; $display("FAIL b2b col_sel k=%0d got %b want %b", k, col_sel, (k < K)); end
         n_cmp++; if (win_done !== (k == K)) begin n_bad++; $display("FAIL b2b win_done k=%0d got %b want %b", k, win_done, (k == K)); end
         if (win_done === 1'b1) pulses++;
         tick();
      end
      #1;
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL b2b end col_valid got %b want 0", col_valid); end
      if (win_done === 1'b1) pulses++;
      n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL b2b win_done pulses got %0d want 2", pulses); end
   endtask

   task automatic test_3x3();
      do_reset();
      kn_size_mode = 1'b1; col_ready = 1'b1; win_data = make_win3(); win_valid = 1'b1;
      tick();
      win_valid = 1'b0; kn_size_mode = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (col_valid !== 1'b1) begin n_bad++; $display("FAIL k3 col_valid c=%0d got %b want 1", c, col_valid); end
         n_cmp++; if (col_data !== exp_col3(c)) begin n_bad++; $display("FAIL k3 col_data c=%0d got %h want %h", c, col_data, exp_col3(c)); end
         n_cmp++; if (col_last !== (c == 2)) begin n_bad++; $display("FAIL k3 col_last c=%0d got %b want %b", c, col_last, (c == 2)); end
         tick();
      end
      #1;
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL k3 end col_valid got %b want 0", col_valid); end
      n_cmp++; if (win_done !== 1'b1) begin n_bad++; $display("FAIL k3 win_done got %b want 1", win_done); end
   endtask

   task automatic test_backpressure();
      int hs;
      int cyc;
      do_reset();
      kn_size_mode = 1'b0; col_ready = 1'b0; win_data = make_win5(4'h7); win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      hs = 0; cyc = 0;
      while (hs < K && cyc < 40) begin
         col_ready = ((cyc % 3) == 0);
         #1;
         n_cmp++; if (col_valid !== 1'b1) begin n_bad++; $display("FAIL bp col_valid cyc=%0d got %b want 1", cyc, col_valid); end
         n_cmp++; if (col_data !== exp_col5(4'h7, hs)) begin n_bad++; $display("FAIL bp col_data cyc=%0d got %h want %h", cyc, col_data, exp_col5(4'h7, hs)); end
         n_cmp++; if (col_last !== (hs == K-1)) begin n_bad++; $display("FAIL bp col_last cyc=%0d got %b want %b", cyc, col_last, (hs == K-1)); end
         n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL bp win_done cyc=%0d got %b want 0", cyc, win_done); end
         if (col_ready) hs++;
         tick();
         cyc++;
      end
      n_cmp++; if (hs != K) begin n_bad++; $display("FAIL bp handshakes got %0d want %0d", hs, K); end
      col_ready = 1'b1;
      #1;
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL bp end col_valid got %b want 0", col_valid); end
      n_cmp++; if (win_done !== 1'b1) begin n_bad++; $display("FAIL bp win_done got %b want 1", win_done); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      kn_size_mode = 1'b0; col_ready = 1'b1; win_data = make_win5(4'h9); win_valid = 1'b1;
      tick();
      win_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++; if (col_data !== exp_col5(4'h9, c)) begin n_bad++; $display("FAIL rstmid col_data c=%0d got %h want %h", c, col_data, exp_col5(4'h9, c)); end
         tick();
      end
      #1;
      n_cmp++; if (col_valid !== 1'b1) begin n_bad++; $display("FAIL rstmid pre col_valid got %b want 1", col_valid); end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid col_valid got %b want 0", col_valid); end
      n_cmp++; if (win_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid win_ready got %b want 1", win_ready); end
      n_cmp++; if (col_sel !== 1'b0) begin n_bad++; $display("FAIL rstmid col_sel got %b want 0", col_sel); end
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL rstmid win_done i=%0d got %b want 0", i, win_done); end
      end
      #2;
      rst_n = 1'b1;
      tick();
      n_cmp++; if (win_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid release win_ready got %b want 1", win_ready); end
      n_cmp++; if (col_sel !== 1'b0) begin n_bad++; $display("FAIL rstmid release col_sel got %b want 0", col_sel); end
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid release col_valid got %b want 0", col_valid); end
      n_cmp++; if (win_done !== 1'b0) begin n_bad++; $display("FAIL rstmid release win_done got %b want 0", win_done); end
   endtask

   // Vertical register model: each accepted column is shifted into the bottom of its group.
   task automatic test_loopback();
      logic [WB-1:0] w;
      logic [WB-1:0] re;
      logic [TN*144-1:0] a_ref;
      logic [TN*144-1:0] a_re;
      int hs;
      int cyc;
      for (int i = 0; i < WB/32; i++) w[i*32 +: 32] = $urandom();
      do_reset();
      kn_size_mode = 1'b0; col_ready = 1'b1; win_data = w; win_valid = 1'b1;
      tick();
      win_valid = 1'b0; re = '0; hs = 0; cyc = 0;
      while (hs < K && cyc < 30) begin
         col_ready = ((cyc % 4) != 2);
         #1;
         if (col_valid && col_ready) begin
            n_cmp++; if (col_sel !== 1'b1) begin n_bad++; $display("FAIL loop5 in_select hs=%0d got %b want 1", hs, col_sel); end
            for (int g = 0; g < TN; g++)
               re[g*GB +: GB] = {re[g*GB +: GB-SB], col_data[g*SB +: SB]};
            hs++;
         end
         tick();
         cyc++;
      end
      n_cmp++; if (re !== w) begin n_bad++; $display("FAIL loop5 window hs=%0d got %h want %h", hs, re[GB-1:0], w[GB-1:0]); end

      for (int i = 0; i < WB/32; i++) w[i*32 +: 32] = $urandom();
      for (int g = 0; g < TN; g++) a_ref[g*144 +: 144] = w[g*GB +: 144];
      kn_size_mode = 1'b1; col_ready = 1'b1; win_data = w; win_valid = 1'b1;
      #1;
      tick();
      win_valid = 1'b0; a_re = '0; hs = 0; cyc = 0;
      while (hs < 3 && cyc < 30) begin
         col_ready = ((cyc % 2) == 0);
         #1;
         if (col_valid && col_ready) begin
            for (int g = 0; g < TN; g++)
               a_re[g*144 +: 144] = {a_re[g*144 +: 96], col_data[g*SB +: 48]};
            hs++;
         end
         tick();
         cyc++;
      end
      n_cmp++; if (a_re !== a_ref) begin n_bad++; $display("FAIL loop3 sub_a hs=%0d got %h want %h", hs, a_re, a_ref); end
      n_cmp++; if (col_valid !== 1'b0) begin n_bad++; $display("FAIL loop3 end col_valid got %b want 0", col_valid); end
   endtask

   initial begin
      test_reset();
      test_single5();
      test_back_to_back();
      test_3x3();
      test_backpressure();
      test_reset_mid();
      test_loopback();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
